// File: rtl/dot8_lane_splitter_pkg.sv
// Shared constants and types for the DOT8 lane splitter.
// The batch and packet-id derivations here must match what the DOT8 unit expects.
package dot8_lane_splitter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } splitState_e;

    function automatic int calcBatches(input int numThreads, input int numLanes);
        return numThreads / numLanes;
    endfunction

    // The packet id stays at least one bit wide even when a warp is a single beat.
    function automatic int calcPidWidth(input int batches);
        return (batches > 1) ? $clog2(batches) : 1;
    endfunction

endpackage

// File: rtl/dot8_lane_splitter_priority_encoder.sv
// Lowest-index-first priority encoder.
// valid_o is low when no input bit is set; index_o is then zero.
module VX_priority_encoder #(
    parameter int N = 4,
    parameter int LN = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  data_i,
    output logic [LN-1:0] index_o,
    output logic          valid_o
);

    // Walking from the top down lets the lowest set bit win.
    always_comb begin
        index_o = '0;
        valid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (data_i[i]) begin
                index_o = LN'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dot8_lane_splitter.sv
// Replays one full-warp DOT8 request as NUM_LANES-wide beats.
// Packets whose thread-mask slice is empty are skipped.
module dot8_lane_splitter
    import dot8_lane_splitter_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int NUM_LANES   = 1,
    parameter int XLEN        = 32,
    parameter int TAG_WIDTH   = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_THREADS-1:0]        in_tmask,
    input  logic [NUM_THREADS*XLEN-1:0]   in_rs1_data,
    input  logic [NUM_THREADS*XLEN-1:0]   in_rs2_data,
    input  logic [TAG_WIDTH-1:0]          in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_LANES-1:0]          out_tmask,
    output logic [NUM_LANES*XLEN-1:0]     out_rs1_data,
    output logic [NUM_LANES*XLEN-1:0]     out_rs2_data,
    output logic [calcPidWidth(calcBatches(NUM_THREADS, NUM_LANES))-1:0] out_pid,
    output logic                          out_sop,
    output logic                          out_eop,
    output logic [TAG_WIDTH-1:0]          out_tag
);

    localparam int BATCHES   = calcBatches(NUM_THREADS, NUM_LANES);
    localparam int PID_WIDTH = calcPidWidth(BATCHES);
    localparam int SLICE_W   = NUM_LANES * XLEN;

    splitState_e                state_q;
    logic [PID_WIDTH-1:0]       pid_q;
    logic                       sop_q;
    logic [NUM_THREADS-1:0]     tmask_q;
    logic [NUM_THREADS*XLEN-1:0] rs1_q;
    logic [NUM_THREADS*XLEN-1:0] rs2_q;
    logic [TAG_WIDTH-1:0]       tag_q;

    logic [BATCHES-1:0]         inPktNz;
    logic [BATCHES-1:0]         curPktNz;
    logic [BATCHES-1:0]         laterPktNz;
    logic [PID_WIDTH-1:0]       firstPid;
    logic                       firstValid;
    logic [PID_WIDTH-1:0]       nextPid;
    logic                       nextValid;
    logic                       inFire;
    logic                       outFire;

    always_comb begin
        inPktNz    = '0;
        curPktNz   = '0;
        laterPktNz = '0;
        for (int p = 0; p < BATCHES; p++) begin
            inPktNz[p]    = |in_tmask[p*NUM_LANES +: NUM_LANES];
            curPktNz[p]   = |tmask_q[p*NUM_LANES +: NUM_LANES];
            laterPktNz[p] = curPktNz[p] && (PID_WIDTH'(p) > pid_q);
        end
    end

    VX_priority_encoder #(
        .N  (BATCHES),
        .LN (PID_WIDTH)
    ) firstEncoder (
        .data_i  (inPktNz),
        .index_o (firstPid),
        .valid_o (firstValid)
    );

    VX_priority_encoder #(
        .N  (BATCHES),
        .LN (PID_WIDTH)
    ) nextEncoder (
        .data_i  (laterPktNz),
        .index_o (nextPid),
        .valid_o (nextValid)
    );

    assign out_valid = (state_q == BUSY);
    assign out_eop   = !nextValid;
    assign out_sop   = sop_q;
    assign out_pid   = pid_q;
    assign outFire   = out_valid && out_ready;
    // Ready reopens on the final handshake so back-to-back warps leave no bubble.
    assign in_ready  = reset && ((state_q == IDLE) || (outFire && out_eop));
    assign inFire    = in_valid && in_ready;

    assign out_tmask    = tmask_q[pid_q*NUM_LANES +: NUM_LANES];
    assign out_rs1_data = rs1_q[pid_q*SLICE_W +: SLICE_W];
    assign out_rs2_data = rs2_q[pid_q*SLICE_W +: SLICE_W];
    assign out_tag      = tag_q;

    // An all-zero mask leaves firstPid at zero, which yields the single empty beat.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            pid_q   <= '0;
            sop_q   <= 1'b0;
            tmask_q <= '0;
        end else if (inFire) begin
            state_q <= BUSY;
            pid_q   <= firstValid ? firstPid : '0;
            sop_q   <= 1'b1;
            tmask_q <= in_tmask;
        end else if (outFire) begin
            if (out_eop) begin
                state_q <= IDLE;
            end else begin
                pid_q <= nextPid;
                sop_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (inFire) begin
            rs1_q <= in_rs1_data;
            rs2_q <= in_rs2_data;
            tag_q <= in_tag;
        end
    end

endmodule

// File: tb/tb_dot8_lane_splitter.sv
// Directed bench for dot8_lane_splitter with four threads and one lane per beat.
// Each task drives one scenario and compares against hand-computed values.
module tb_dot8_lane_splitter;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_tmask;
    logic [127:0]  in_rs1_data;
    logic [127:0]  in_rs2_data;
    logic [63:0]   in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [0:0]    out_tmask;
    logic [31:0]   out_rs1_data;
    logic [31:0]   out_rs2_data;
    logic [1:0]    out_pid;
    logic          out_sop;
    logic          out_eop;
    logic [63:0]   out_tag;

    int testsRun;
    int testsFailed;

    dot8_lane_splitter #(
        .NUM_THREADS (4),
        .NUM_LANES   (1),
        .XLEN        (32),
        .TAG_WIDTH   (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_tmask     (in_tmask),
        .in_rs1_data  (in_rs1_data),
        .in_rs2_data  (in_rs2_data),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_tmask    (out_tmask),
        .out_rs1_data (out_rs1_data),
        .out_rs2_data (out_rs2_data),
        .out_pid      (out_pid),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .out_tag      (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one request for a single cycle; rs1[i] = i+1, rs2[i] = i+17.
    task automatic applyStimulus(input logic [3:0] mask, input logic [63:0] tag);
        in_valid = 1'b1;
        in_tmask = mask;
        in_tag   = tag;
        for (int i = 0; i < 4; i++) begin
            in_rs1_data[i*32 +: 32] = 32'(i + 1);
            in_rs2_data[i*32 +: 32] = 32'(i + 17);
        end
        #1;
        testsRun++;
        if (in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL req_ready: in_ready=%b expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_tmask  = '0;
        in_rs1_data = '0;
        in_rs2_data = '0;
        in_tag    = '0;
        repeat (2) @(negedge clk);
        #1;
        testsRun++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_hold: valid=%b ready=%b expected 0/0", out_valid, in_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        testsRun++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_idle: valid=%b ready=%b expected 0/1", out_valid, in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_full_mask();
        out_ready = 1'b1;
        applyStimulus(4'b1111, 64'hCAFE_0000_0000_0001);
        for (int p = 0; p < 4; p++) begin
            #1;
            testsRun++;
            if (out_valid !== 1'b1 || out_pid !== 2'(p) || out_sop !== (p == 0) ||
                out_eop !== (p == 3) || out_rs1_data !== 32'(p + 1) ||
                out_rs2_data !== 32'(p + 17) || out_tmask !== 1'b1 ||
                out_tag !== 64'hCAFE_0000_0000_0001) begin
                testsFailed++;
                $display("[TB] FAIL full_beat%0d: v=%b pid=%0d sop=%b eop=%b rs1=%0d rs2=%0d tm=%b expected pid=%0d rs1=%0d",
                         p, out_valid, out_pid, out_sop, out_eop, out_rs1_data, out_rs2_data, out_tmask, p, p + 1);
            end
            @(negedge clk);
        end
        #1;
        testsRun++;
        if (out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL full_done: out_valid=%b expected 0", out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_sparse();
        logic [1:0] expPid [2];
        expPid[0] = 2'd1;
        expPid[1] = 2'd3;
        applyStimulus(4'b1010, 64'h0000_0000_0000_00A5);
        for (int b = 0; b < 2; b++) begin
            #1;
            testsRun++;
            if (out_valid !== 1'b1 || out_pid !== expPid[b] || out_sop !== (b == 0) ||
                out_eop !== (b == 1) || out_rs1_data !== 32'(expPid[b]) + 32'd1) begin
                testsFailed++;
                $display("[TB] FAIL sparse_beat%0d: v=%b pid=%0d sop=%b eop=%b rs1=%0d expected pid=%0d",
                         b, out_valid, out_pid, out_sop, out_eop, out_rs1_data, expPid[b]);
            end
            @(negedge clk);
        end
        #1;
        testsRun++;
        if (out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL sparse_done: out_valid=%b expected 0", out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_mask();
        applyStimulus(4'b0000, 64'h0);
        #1;
        testsRun++;
        if (out_valid !== 1'b1 || out_pid !== 2'd0 || out_tmask !== 1'b0 ||
            out_sop !== 1'b1 || out_eop !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL zero_beat: v=%b pid=%0d tm=%b sop=%b eop=%b expected 1/0/0/1/1",
                     out_valid, out_pid, out_tmask, out_sop, out_eop);
        end
        @(negedge clk);
        #1;
        testsRun++;
        if (out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL zero_done: out_valid=%b expected 0", out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        applyStimulus(4'b1111, 64'h1234);
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            testsRun++;
            if (out_valid !== 1'b1 || out_pid !== 2'd1 || out_rs1_data !== 32'd2 ||
                out_rs2_data !== 32'd18 || out_sop !== 1'b0 || out_eop !== 1'b0 ||
                out_tmask !== 1'b1 || in_ready !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL stall%0d: v=%b pid=%0d rs1=%0d sop=%b eop=%b rdy=%b expected pid=1 rs1=2 rdy=0",
                         k, out_valid, out_pid, out_rs1_data, out_sop, out_eop, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        testsRun++;
        if (out_valid !== 1'b1 || out_pid !== 2'd2 || out_rs1_data !== 32'd3) begin
            testsFailed++;
            $display("[TB] FAIL stall_resume: v=%b pid=%0d rs1=%0d expected pid=2 rs1=3",
                     out_valid, out_pid, out_rs1_data);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        applyStimulus(4'b0001, 64'h1111);
        in_valid = 1'b1;
        in_tmask = 4'b1000;
        in_tag   = 64'h2222;
        #1;
        testsRun++;
        if (out_valid !== 1'b1 || out_pid !== 2'd0 || out_sop !== 1'b1 ||
            out_eop !== 1'b1 || in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL b2b_first: v=%b pid=%0d sop=%b eop=%b rdy=%b expected 1/0/1/1/1",
                     out_valid, out_pid, out_sop, out_eop, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        testsRun++;
        if (out_valid !== 1'b1 || out_pid !== 2'd3 || out_sop !== 1'b1 || out_eop !== 1'b1 ||
            out_tmask !== 1'b1 || out_rs1_data !== 32'd4 || out_tag !== 64'h2222) begin
            testsFailed++;
            $display("[TB] FAIL b2b_second: v=%b pid=%0d sop=%b eop=%b rs1=%0d tag=%h expected pid=3 rs1=4 tag=2222",
                     out_valid, out_pid, out_sop, out_eop, out_rs1_data, out_tag);
        end
        @(negedge clk);
        #1;
        testsRun++;
        if (out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_done: out_valid=%b expected 0", out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        out_ready = 1'b1;
        applyStimulus(4'b1111, 64'h3333);
        @(negedge clk);
        reset = 1'b0;
        #1;
        testsRun++;
        if (out_pid !== 2'd1 || in_ready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midrst_cycle: pid=%0d rdy=%b expected pid=1 rdy=0", out_pid, in_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        testsRun++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL midrst_idle: v=%b rdy=%b expected 0/1", out_valid, in_ready);
        end
        applyStimulus(4'b1111, 64'h4444);
        #1;
        testsRun++;
        if (out_valid !== 1'b1 || out_pid !== 2'd0 || out_sop !== 1'b1 || out_rs1_data !== 32'd1) begin
            testsFailed++;
            $display("[TB] FAIL midrst_restart: v=%b pid=%0d sop=%b rs1=%0d expected 1/0/1/1",
                     out_valid, out_pid, out_sop, out_rs1_data);
        end
        repeat (4) @(negedge clk);
        #1;
        testsRun++;
        if (out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midrst_done: out_valid=%b expected 0", out_valid);
        end
        @(negedge clk);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        test_reset();
        test_full_mask();
        test_sparse();
        test_zero_mask();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
